char_receiver: RTL and testbench

- Single-clock serial character receiver for the text-display path.
- Deserialises 10-bit frames from the line `inputCharBit`, at one bit per `cclk`: start bit 0, 8 data bits LSB first, stop bit 1. The line idles high.
- Maps each received letter code to ASCII and appends it to a 26-entry character buffer.
- Every buffer entry is exposed as its own 8-bit output, `char0`..`char25`, for the downstream display/renderer.

---
 rtl/char_receiver_pkg.sv | 29 ++
 rtl/char_rx_deser.sv | 66 ++++++
 rtl/char_receiver.sv | 91 +++++++++
 tb/tb_char_receiver.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_receiver_pkg.sv
// Shared constants, FSM state type and letter-code to ASCII mapping for the
// serial character receiver.
package char_receiver_pkg;

  localparam int        NUM_CHARS  = 26;
  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] BAD_CHAR   = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  // 0 is a space, 1..26 are 'A'..'Z', anything else is shown as '?'
  function automatic logic [7:0] map_code(input logic [7:0] code);
    logic [7:0] ascii;
    if (code == 8'd0)
      ascii = BLANK_CHAR;
    else if (code <= 8'd26)
      ascii = ASCII_A + code - 8'd1;
    else
      ascii = BAD_CHAR;
    return ascii;
  endfunction

endpackage

// File: rtl/char_rx_deser.sv
// Frame deserialiser: start bit, 8 data bits LSB first, stop bit, one sample
// per cclk. Emits a one-cycle byte_valid pulse for every well-framed byte.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | line idle, waiting for a 0 start bit
// ST_DATA      | capturing data bits 0..7 into shift
// ST_STOP      | expecting stop bit 1; commit on 1, framing error on 0
// ST_WAIT_IDLE | after a framing error, wait for the line to return high
module char_rx_deser
  import char_receiver_pkg::*;
(
  input  logic       cclk,
  input  logic       rstb,
  input  logic       line,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  rx_state_t  state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
    end else begin
      byte_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!line) begin
            state   <= ST_DATA;
            bit_cnt <= 3'd0;
          end
        end
        ST_DATA: begin
          shift[bit_cnt] <= line;
          if (bit_cnt == 3'd7)
            state <= ST_STOP;
          else
            bit_cnt <= bit_cnt + 3'd1;
        end
        ST_STOP: begin
          if (line) begin
            byte_valid <= 1'b1;
            byte_data  <= shift;
            state      <= ST_IDLE;
          end else begin
            state <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          // a stuck-low line must not be read as an endless run of frames
          if (line)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/char_receiver.sv
// Serial character receiver: deserialises frames, maps codes to ASCII and
// appends them to a 26-entry wrapping display buffer.
module char_receiver
  import char_receiver_pkg::*;
(
  input  logic       cclk,
  input  logic       rstb,
  input  logic       inputCharBit,
  output logic [7:0] char0,
  output logic [7:0] char1,
  output logic [7:0] char2,
  output logic [7:0] char3,
  output logic [7:0] char4,
  output logic [7:0] char5,
  output logic [7:0] char6,
  output logic [7:0] char7,
  output logic [7:0] char8,
  output logic [7:0] char9,
  output logic [7:0] char10,
  output logic [7:0] char11,
  output logic [7:0] char12,
  output logic [7:0] char13,
  output logic [7:0] char14,
  output logic [7:0] char15,
  output logic [7:0] char16,
  output logic [7:0] char17,
  output logic [7:0] char18,
  output logic [7:0] char19,
  output logic [7:0] char20,
  output logic [7:0] char21,
  output logic [7:0] char22,
  output logic [7:0] char23,
  output logic [7:0] char24,
  output logic [7:0] char25
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_CHARS - 1);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic [7:0] chars [NUM_CHARS];
  logic [4:0] wptr;

  char_rx_deser u_deser (
    .cclk       (cclk),
    .rstb       (rstb),
    .line       (inputCharBit),
    .byte_valid (byte_valid),
    .byte_data  (byte_data)
  );

  // wrapping overwrites one entry per commit; there is no bulk clear
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < NUM_CHARS; i++)
        chars[i] <= BLANK_CHAR;
      wptr <= 5'd0;
    end else if (byte_valid) begin
      chars[wptr] <= map_code(byte_data);
      wptr        <= (wptr == LAST_IDX) ? 5'd0 : wptr + 5'd1;
    end
  end

  assign char0  = chars[0];
  assign char1  = chars[1];
  assign char2  = chars[2];
  assign char3  = chars[3];
  assign char4  = chars[4];
  assign char5  = chars[5];
  assign char6  = chars[6];
  assign char7  = chars[7];
  assign char8  = chars[8];
  assign char9  = chars[9];
  assign char10 = chars[10];
  assign char11 = chars[11];
  assign char12 = chars[12];
  assign char13 = chars[13];
  assign char14 = chars[14];
  assign char15 = chars[15];
  assign char16 = chars[16];
  assign char17 = chars[17];
  assign char18 = chars[18];
  assign char19 = chars[19];
  assign char20 = chars[20];
  assign char21 = chars[21];
  assign char22 = chars[22];
  assign char23 = chars[23];
  assign char24 = chars[24];
  assign char25 = chars[25];

endmodule

// File: tb/tb_char_receiver.sv
// Self-checking bench for char_receiver: drives serial frames and compares all
// 26 outputs against a simple buffer model after each commit.
module tb_char_receiver;

  logic       cclk;
  logic       rstb;
  logic       line;
  logic [7:0] dut_chars [26];

  logic [7:0] model [26];
  int         mptr;
  int         tests;
  int         fails;

  char_receiver dut (
    .cclk         (cclk),
    .rstb         (rstb),
    .inputCharBit (line),
    .char0  (dut_chars[0]),  .char1  (dut_chars[1]),  .char2  (dut_chars[2]),
    .char3  (dut_chars[3]),  .char4  (dut_chars[4]),  .char5  (dut_chars[5]),
    .char6  (dut_chars[6]),  .char7  (dut_chars[7]),  .char8  (dut_chars[8]),
    .char9  (dut_chars[9]),  .char10 (dut_chars[10]), .char11 (dut_chars[11]),
    .char12 (dut_chars[12]), .char13 (dut_chars[13]), .char14 (dut_chars[14]),
    .char15 (dut_chars[15]), .char16 (dut_chars[16]), .char17 (dut_chars[17]),
    .char18 (dut_chars[18]), .char19 (dut_chars[19]), .char20 (dut_chars[20]),
    .char21 (dut_chars[21]), .char22 (dut_chars[22]), .char23 (dut_chars[23]),
    .char24 (dut_chars[24]), .char25 (dut_chars[25])
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  function automatic logic [7:0] expect_ascii(input int code);
    if (code == 0) return 8'h20;
    if (code <= 26) return 8'(64 + code);
    return 8'h3F;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 26; i++) model[i] = 8'h20;
    mptr = 0;
  endtask

  task automatic model_commit(input int code);
    model[mptr] = expect_ascii(code);
    mptr = (mptr + 1) % 26;
  endtask

  // each bit is driven on a falling edge and sampled on the following rising edge
  task automatic send_bits(input logic [7:0] code, input logic stop);
    @(negedge cclk) line = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge cclk) line = code[i];
    end
    @(negedge cclk) line = stop;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge cclk) line = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge cclk);
    rstb = 1'b0;
    line = 1'b1;
    repeat (2) @(negedge cclk);
    rstb = 1'b1;
    model_clear();
    idle(2);
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    line = 1'b1;
    repeat (3) @(negedge cclk);
    for (int i = 0; i < 26; i++) begin
      tests++;
      if (dut_chars[i] !== 8'h20) begin
        fails++;
        $display("FAIL reset_hold char%0d got %h want 20", i, dut_chars[i]);
      end
    end
    rstb = 1'b1;
    model_clear();
    idle(20);
    for (int i = 0; i < 26; i++) begin
      tests++;
      if (dut_chars[i] !== 8'h20) begin
        fails++;
        $display("FAIL reset_idle char%0d got %h want 20", i, dut_chars[i]);
      end
    end
  endtask

  task automatic test_single();
    send_bits(8'd1, 1'b1);
    idle(1);
    @(posedge cclk); #1;
    model_commit(1);
    for (int i = 0; i < 26; i++) begin
      tests++;
      if (dut_chars[i] !== model[i]) begin
        fails++;
        $display("FAIL single char%0d got %h want %h", i, dut_chars[i], model[i]);
      end
    end
  endtask

  task automatic test_sequence();
    int codes [7] = '{1, 7, 5, 3, 5, 7, 1};
    for (int f = 0; f < 7; f++) begin
      send_bits(8'(codes[f]), 1'b1);
      idle(1);
      @(posedge cclk); #1;
      model_commit(codes[f]);
      for (int i = 0; i < 26; i++) begin
        tests++;
        if (dut_chars[i] !== model[i]) begin
          fails++;
          $display("FAIL sequence f%0d char%0d got %h want %h", f, i, dut_chars[i], model[i]);
        end
      end
      idle(99);
    end
  endtask

  task automatic test_wrap();
    int gap;
    do_reset();
    for (int f = 0; f < 28; f++) begin
      int code = (f < 27) ? 2 : 26;
      gap = $urandom_range(0, 3);
      send_bits(8'(code), 1'b1);
      model_commit(code);
      if (gap > 0) begin
        idle(1);
        @(posedge cclk); #1;
        for (int i = 0; i < 26; i++) begin
          tests++;
          if (dut_chars[i] !== model[i]) begin
            fails++;
            $display("FAIL wrap f%0d char%0d got %h want %h", f, i, dut_chars[i], model[i]);
          end
        end
        idle(gap - 1);
      end
    end
    idle(3);
    tests++;
    if (dut_chars[1] !== 8'h5A || dut_chars[0] !== 8'h42 || dut_chars[25] !== 8'h42) begin
      fails++;
      $display("FAIL wrap_final c0 %h c1 %h c25 %h want 42 5a 42",
               dut_chars[0], dut_chars[1], dut_chars[25]);
    end
  endtask

  task automatic test_framing();
    send_bits(8'($urandom_range(1, 26)), 1'b0);
    idle(0);
    @(negedge cclk) line = 1'b0;
    repeat (19) @(negedge cclk) line = 1'b0;
    idle(5);
    for (int i = 0; i < 26; i++) begin
      tests++;
      if (dut_chars[i] !== model[i]) begin
        fails++;
        $display("FAIL framing_err char%0d got %h want %h", i, dut_chars[i], model[i]);
      end
    end
    send_bits(8'd0, 1'b1);
    idle(1);
    @(posedge cclk); #1;
    model_commit(0);
    send_bits(8'd200, 1'b1);
    idle(1);
    @(posedge cclk); #1;
    model_commit(200);
    for (int i = 0; i < 26; i++) begin
      tests++;
      if (dut_chars[i] !== model[i]) begin
        fails++;
        $display("FAIL framing_map char%0d got %h want %h", i, dut_chars[i], model[i]);
      end
    end
  endtask

  task automatic test_random();
    int  gap;
    int  code;
    logic bad;
    for (int f = 0; f < 60; f++) begin
      code = $urandom_range(0, 255);
      bad  = ($urandom_range(0, 7) == 0);
      gap  = $urandom_range(bad ? 1 : 0, 4);
      send_bits(8'(code), !bad);
      if (!bad) model_commit(code);
      if (gap > 0) begin
        idle(1);
        @(posedge cclk); #1;
        for (int i = 0; i < 26; i++) begin
          tests++;
          if (dut_chars[i] !== model[i]) begin
            fails++;
            $display("FAIL random f%0d char%0d got %h want %h", f, i, dut_chars[i], model[i]);
          end
        end
        idle(gap - 1);
      end
    end
    idle(3);
  endtask

  task automatic test_async_reset();
    @(negedge cclk) line = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge cclk) line = 1'($urandom_range(0, 1));
    end
    #2 rstb = 1'b0;
    #1;
    for (int i = 0; i < 26; i++) begin
      tests++;
      if (dut_chars[i] !== 8'h20) begin
        fails++;
        $display("FAIL async_reset char%0d got %h want 20", i, dut_chars[i]);
      end
    end
    model_clear();
    @(negedge cclk) line = 1'b1;
    @(negedge cclk) rstb = 1'b1;
    idle(3);
    send_bits(8'd19, 1'b1);
    idle(1);
    @(posedge cclk); #1;
    model_commit(19);
    for (int i = 0; i < 26; i++) begin
      tests++;
      if (dut_chars[i] !== model[i]) begin
        fails++;
        $display("FAIL async_fresh char%0d got %h want %h", i, dut_chars[i], model[i]);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rstb  = 1'b0;
    line  = 1'b1;
    model_clear();
    test_reset();
    test_single();
    test_sequence();
    test_wrap();
    test_framing();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
